// File: rtl/md_unit.sv
// md_unit: multiply/divide unit owning the HI/LO registers.
// A multiply or divide is computed combinationally at acceptance, parked in
// pending registers, and committed to hi/lo when the busy window expires, so
// hi/lo timing matches a multi-cycle iterative unit.
// Optional feature macro: MD_UNIT_DIV_EN enables div/divu (ALUop 26/27).
// Without it those codes are treated as non-MD and no divider is built.
//
// Handshake: a request is taken only in IDLE when en=1 and md=1 with a valid
// MD opcode (or en=1, mt=1, md=0 for mthi/mtlo). There is no ready signal;
// the surrounding pipeline stalls on busy, and requests arriving while busy
// are dropped without side effects.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic        md,
  input  logic        mt,
  input  logic [7:0]  ALUop,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      pend_hi, pend_lo;
  logic             pend_wr;

  logic             is_mult, is_multu, is_md_op;
  logic             start, mt_go, done;
  logic [31:0]      res_hi, res_lo;
  logic             res_wr;
  logic [CNT_W-1:0] res_cyc;
  logic [63:0]      prod;

  // Opcode decode and request acceptance.
  always_comb begin
    is_mult  = (ALUop == 8'd24);
    is_multu = (ALUop == 8'd25);
`ifdef MD_UNIT_DIV_EN
    is_md_op = is_mult || is_multu || (ALUop == 8'd26) || (ALUop == 8'd27);
`else
    is_md_op = is_mult || is_multu;
`endif
    start = en && md && is_md_op && (state == IDLE);
    // md has priority over mt when both are raised together.
    mt_go = en && mt && !md && (state == IDLE);
    // Terminal count is 1; <= also covers a zero-cycle configuration.
    done  = (state == BUSY) && (cnt <= CNT_W'(1));
  end

  // Result datapath: full 64-bit product and optional divider.
  always_comb begin
    res_hi  = 32'd0;
    res_lo  = 32'd0;
    res_wr  = 1'b1;
    res_cyc = CNT_W'(MULT_CYCLES);
    if (is_mult)
      prod = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    else
      prod = {32'd0, A} * {32'd0, B};
    if (is_mult || is_multu) begin
      res_hi = prod[63:32];
      res_lo = prod[31:0];
    end
`ifdef MD_UNIT_DIV_EN
    else begin
      res_cyc = CNT_W'(DIV_CYCLES);
      if (B == 32'd0) begin
        // Divide by zero still occupies the unit but commits nothing.
        res_wr = 1'b0;
      end else if (ALUop == 8'd26) begin
        if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
          // The only signed overflow case; pin the architectural result.
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          res_lo = $signed(A) / $signed(B);
          res_hi = $signed(A) % $signed(B);
        end
      end else begin
        res_lo = A / B;
        res_hi = A % B;
      end
    end
`endif
  end

  // Next-state and counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = BUSY;
          cnt_nxt   = res_cyc;
        end
      end
      BUSY: begin
        if (done) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State register and down-counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Pending result capture at acceptance.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else if (start) begin
      pend_hi <= res_hi;
      pend_lo <= res_lo;
      pend_wr <= res_wr;
    end
  end

  // HI/LO update: commit at end of busy window, or direct mthi/mtlo write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (done) begin
      if (pend_wr) begin
        hi <= pend_hi;
        lo <= pend_lo;
      end
    end else if (mt_go) begin
      if (ALUop == 8'd28) hi <= A;
      if (ALUop == 8'd29) lo <= A;
    end
  end

  assign busy = (state == BUSY);

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: table of single-request vectors followed
// by hand-written collision and reset-abort sequences. Works with or without
// MD_UNIT_DIV_EN defined.
module tb_md_unit;

`ifdef MD_UNIT_DIV_EN
  localparam bit DIV_ON = 1'b1;
`else
  localparam bit DIV_ON = 1'b0;
`endif

  logic        clk;
  logic        reset_n;
  logic        en, md, mt;
  logic [7:0]  ALUop;
  logic [31:0] A, B;
  logic        busy;
  logic [31:0] hi, lo;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    bit          en, md, mt;
    logic [7:0]  op;
    logic [31:0] a, b;
    int          cyc;
    logic [31:0] hi, lo;
  } vec_t;

  vec_t vecs[$];

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .md(md), .mt(mt),
    .ALUop(ALUop), .A(A), .B(B), .busy(busy), .hi(hi), .lo(lo)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic clear_inputs();
    en = 1'b0; md = 1'b0; mt = 1'b0; ALUop = 8'd0; A = 32'd0; B = 32'd0;
  endtask

  task automatic add(input string nm, input bit e, input bit m, input bit t,
                     input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                     input int cyc, input logic [31:0] h, input logic [31:0] l);
    vec_t v;
    v.name = nm; v.en = e; v.md = m; v.mt = t; v.op = op; v.a = a; v.b = b;
    v.cyc = cyc; v.hi = h; v.lo = l;
    vecs.push_back(v);
  endtask

  // Apply one request, count busy cycles, check hi/lo hold and final values.
  task automatic run_vec(input vec_t v, input logic [31:0] ph, input logic [31:0] pl);
    int cyc;
    bit stable;
    @(negedge clk);
    en = v.en; md = v.md; mt = v.mt; ALUop = v.op; A = v.a; B = v.b;
    @(posedge clk); #1;
    clear_inputs();
    cyc = 0;
    stable = 1'b1;
    while (busy && cyc < 40) begin
      cyc++;
      if (hi !== ph || lo !== pl) stable = 1'b0;
      @(posedge clk); #1;
    end
    chk({v.name, " cycles"}, 32'(cyc), 32'(v.cyc));
    if (v.cyc > 0) chk({v.name, " hold"}, {31'd0, stable}, 32'd1);
    chk({v.name, " hi"}, hi, v.hi);
    chk({v.name, " lo"}, lo, v.lo);
  endtask

  initial begin
    logic [31:0] ph, pl;
    vec_t tmp;
    int cyc;

    clear_inputs();
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset hi", hi, 32'd0);
    chk("reset lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;

    add("mult_neg2x3",   1, 1, 0, 8'd24, 32'hFFFF_FFFE, 32'd3,        5, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    add("multu_max",     1, 1, 0, 8'd25, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, 32'hFFFF_FFFE, 32'h0000_0001);
    add("mthi",          1, 0, 1, 8'd28, 32'h1234_5678, 32'd0,        0, 32'h1234_5678, 32'h0000_0001);
    add("mtlo",          1, 0, 1, 8'd29, 32'h9ABC_DEF0, 32'd0,        0, 32'h1234_5678, 32'h9ABC_DEF0);
    add("mult_en0",      0, 1, 0, 8'd24, 32'd5,         32'd5,        0, 32'h1234_5678, 32'h9ABC_DEF0);
    add("md_badop",      1, 1, 0, 8'd30, 32'd5,         32'd5,        0, 32'h1234_5678, 32'h9ABC_DEF0);
    add("mt_badop",      1, 0, 1, 8'd24, 32'd5,         32'd5,        0, 32'h1234_5678, 32'h9ABC_DEF0);
    add("mult_7xm3",     1, 1, 0, 8'd24, 32'd7,         32'hFFFF_FFFD, 5, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    add("multu_carry",   1, 1, 0, 8'd25, 32'h8000_0000, 32'd2,        5, 32'h0000_0001, 32'h0000_0000);
    add("div_m7d2",      1, 1, 0, 8'd26, 32'hFFFF_FFF9, 32'd2,
        DIV_ON ? 10 : 0, DIV_ON ? 32'hFFFF_FFFF : 32'h1, DIV_ON ? 32'hFFFF_FFFD : 32'h0);
    add("divu_by0",      1, 1, 0, 8'd27, 32'd100,       32'd0,
        DIV_ON ? 10 : 0, DIV_ON ? 32'hFFFF_FFFF : 32'h1, DIV_ON ? 32'hFFFF_FFFD : 32'h0);
    add("div_ovf",       1, 1, 0, 8'd26, 32'h8000_0000, 32'hFFFF_FFFF,
        DIV_ON ? 10 : 0, DIV_ON ? 32'h0 : 32'h1, DIV_ON ? 32'h8000_0000 : 32'h0);
    add("divu_max16",    1, 1, 0, 8'd27, 32'hFFFF_FFFF, 32'd16,
        DIV_ON ? 10 : 0, DIV_ON ? 32'hF : 32'h1, DIV_ON ? 32'h0FFF_FFFF : 32'h0);
    add("div_7dm2",      1, 1, 0, 8'd26, 32'd7,         32'hFFFF_FFFE,
        DIV_ON ? 10 : 0, 32'h1, DIV_ON ? 32'hFFFF_FFFD : 32'h0);
    add("md_and_mt",     1, 1, 1, 8'd24, 32'd3,         32'd4,        5, 32'h0, 32'h0000_000C);

    ph = 32'd0;
    pl = 32'd0;
    foreach (vecs[i]) begin
      run_vec(vecs[i], ph, pl);
      ph = vecs[i].hi;
      pl = vecs[i].lo;
    end

    // mult 6*7 with mtlo at busy cycle 2 and a stray mult at busy cycle 3.
    @(negedge clk);
    en = 1; md = 1; ALUop = 8'd24; A = 32'd6; B = 32'd7;
    @(posedge clk); #1;
    clear_inputs();
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      if (cyc == 2) begin
        clear_inputs(); en = 1; mt = 1; ALUop = 8'd29; A = 32'd1;
      end else if (cyc == 3) begin
        clear_inputs(); en = 1; md = 1; ALUop = 8'd24; A = 32'd2; B = 32'd2;
      end else begin
        clear_inputs();
      end
      @(posedge clk); #1;
    end
    clear_inputs();
    chk("collide cycles", 32'(cyc), 32'd5);
    chk("collide hi", hi, 32'd0);
    chk("collide lo", lo, 32'h0000_002A);
    @(posedge clk); #1;
    chk("collide no restart", {31'd0, busy}, 32'd0);

    // Give hi a nonzero value, then abort an operation with reset.
    tmp.name = "mthi_pre"; tmp.en = 1; tmp.md = 0; tmp.mt = 1; tmp.op = 8'd28;
    tmp.a = 32'h0000_0055; tmp.b = 32'd0; tmp.cyc = 0; tmp.hi = 32'h55; tmp.lo = 32'h2A;
    run_vec(tmp, 32'd0, 32'h2A);
    @(negedge clk);
    en = 1; md = 1; ALUop = DIV_ON ? 8'd26 : 8'd24; A = 32'hFFFF_FFF9; B = 32'd2;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("abort busy before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort hi", hi, 32'd0);
    chk("abort lo", lo, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    chk("abort discarded hi", hi, 32'd0);
    chk("abort discarded lo", lo, 32'd0);

    tmp.name = "mult_after_rst"; tmp.en = 1; tmp.md = 1; tmp.mt = 0; tmp.op = 8'd24;
    tmp.a = 32'hFFFF_FFFE; tmp.b = 32'd3; tmp.cyc = 5; tmp.hi = 32'hFFFF_FFFF; tmp.lo = 32'hFFFF_FFFA;
    run_vec(tmp, 32'd0, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
